// File: rtl/logic_op_unit.sv
// Registered two-operand bitwise logic unit with eight functions and a
// built-in sequencer that sweeps every (a,b) combination through the latched function.
module logic_op_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sweep_start,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = 2 * WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [WIDTH-1:0] out_a_reg, out_a_next;
  logic [WIDTH-1:0] out_b_reg, out_b_next;
  logic             out_valid_reg, out_valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             in_sweep;
  logic [2:0]       fn_sel;
  logic [WIDTH-1:0] opd_a, opd_b, fn_out;

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (f)
      3'd0:    r = x & z;
      3'd1:    r = x | z;
      3'd2:    r = x ^ z;
      3'd3:    r = ~(x ^ z);
      3'd4:    r = ~(x & z);
      3'd5:    r = ~(x | z);
      3'd6:    r = ~x | z;
      default: r = x | ~z;
    endcase
    return r;
  endfunction

  // One shared evaluator: the sweep feeds it counter halves (B fastest) and the latched op.
  assign in_sweep = (state_reg == SWEEP);
  assign fn_sel   = in_sweep ? op_reg : op;
  assign opd_a    = in_sweep ? cnt_reg[CW-1:WIDTH] : a;
  assign opd_b    = in_sweep ? cnt_reg[WIDTH-1:0] : b;
  assign fn_out   = logic_fn(fn_sel, opd_a, opd_b);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    y_next         = y_reg;
    out_a_next     = out_a_reg;
    out_b_next     = out_b_reg;
    out_valid_next = 1'b0;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sweep_start) begin
          op_next    = op;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = SWEEP;
        end else if (in_valid) begin
          y_next         = fn_out;
          out_a_next     = opd_a;
          out_b_next     = opd_b;
          out_valid_next = 1'b1;
        end
      end
      SWEEP: begin
        y_next         = fn_out;
        out_a_next     = opd_a;
        out_b_next     = opd_b;
        out_valid_next = 1'b1;
        if (&cnt_reg) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= '0;
      y_reg         <= '0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      y_reg         <= y_next;
      out_a_reg     <= out_a_next;
      out_b_reg     <= out_b_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign y         = y_reg;
  assign out_a     = out_a_reg;
  assign out_b     = out_b_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_logic_op_unit.sv
// Directed bench for logic_op_unit: a WIDTH=4 instance for single ops and
// long sweeps, a WIDTH=1 instance for short truth-table sweeps.
module tb_logic_op_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic [2:0] op4;
  logic       in_valid4, sweep_start4;
  logic [3:0] a4, b4, y4, out_a4, out_b4;
  logic       out_valid4, busy4, done4;

  // WIDTH=1 instance
  logic [2:0] op1;
  logic       in_valid1, sweep_start1;
  logic [0:0] a1, b1, y1, out_a1, out_b1;
  logic       out_valid1, busy1, done1;

  logic_op_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .op(op4), .in_valid(in_valid4), .a(a4), .b(b4),
    .sweep_start(sweep_start4), .y(y4), .out_a(out_a4), .out_b(out_b4),
    .out_valid(out_valid4), .busy(busy4), .done(done4)
  );

  logic_op_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .op(op1), .in_valid(in_valid1), .a(a1), .b(b1),
    .sweep_start(sweep_start1), .y(y1), .out_a(out_a1), .out_b(out_b1),
    .out_valid(out_valid1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle4(input string tag);
    check({tag, ".y"}, 32'(y4), 32'h0);
    check({tag, ".out_a"}, 32'(out_a4), 32'h0);
    check({tag, ".out_b"}, 32'(out_b4), 32'h0);
    check({tag, ".out_valid"}, 32'(out_valid4), 32'h0);
    check({tag, ".busy"}, 32'(busy4), 32'h0);
    check({tag, ".done"}, 32'(done4), 32'h0);
  endtask

  // Hand-computed: a=1100, b=1010 through ops 0..7
  logic [3:0] single_exp [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                                 4'b0111, 4'b0001, 4'b1011, 4'b1101};
  // WIDTH=1 truth tables for (a,b)=00,01,10,11
  logic [3:0] imp_exp = 4'b1011;  // bit i = result for index i
  logic [3:0] xor_exp = 4'b0110;

  task automatic sweep1(input logic [2:0] f, input logic [3:0] tbl, input string tag);
    op1 = f;
    sweep_start1 = 1'b1;
    tick();
    sweep_start1 = 1'b0;
    check({tag, ".start_busy"}, 32'(busy1), 32'h1);
    check({tag, ".start_noval"}, 32'(out_valid1), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("%s result %0d: a=%0d b=%0d y=%0d done=%0d busy=%0d", tag, i, out_a1, out_b1, y1, done1, busy1);
      check({tag, ".y"}, 32'(y1), 32'(tbl[i]));
      check({tag, ".out_a"}, 32'(out_a1), 32'(i >> 1));
      check({tag, ".out_b"}, 32'(out_b1), 32'(i & 1));
      check({tag, ".out_valid"}, 32'(out_valid1), 32'h1);
      check({tag, ".done"}, 32'(done1), 32'(i == 3));
      check({tag, ".busy"}, 32'(busy1), 32'(i != 3));
    end
    tick();
    check({tag, ".after_valid"}, 32'(out_valid1), 32'h0);
    check({tag, ".after_done"}, 32'(done1), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    op4 = '0; in_valid4 = 1'b0; sweep_start4 = 1'b0; a4 = '0; b4 = '0;
    op1 = '0; in_valid1 = 1'b0; sweep_start1 = 1'b0; a1 = '0; b1 = '0;

    // Reset held two cycles, then released with no requests
    tick();
    tick();
    check_idle4("reset");
    check("reset.w1_busy", 32'(busy1), 32'h0);
    check("reset.w1_valid", 32'(out_valid1), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check_idle4("post_reset");

    // Single ops back to back
    a4 = 4'b1100;
    b4 = 4'b1010;
    in_valid4 = 1'b1;
    op4 = 3'd0;
    for (int k = 0; k < 8; k++) begin
      tick();
      $display("single op=%0d: y=%b out_valid=%0d", k, y4, out_valid4);
      check("single.y", 32'(y4), 32'(single_exp[k]));
      check("single.valid", 32'(out_valid4), 32'h1);
      check("single.out_a", 32'(out_a4), 32'hC);
      check("single.out_b", 32'(out_b4), 32'hA);
      check("single.busy", 32'(busy4), 32'h0);
      if (k < 7) op4 = 3'(k + 1);
      else in_valid4 = 1'b0;
    end
    tick();
    check("single.valid_drop", 32'(out_valid4), 32'h0);
    check("single.y_hold", 32'(y4), 32'hD);

    // WIDTH=1 sweeps
    sweep1(3'd6, imp_exp, "w1_imp");
    sweep1(3'd2, xor_exp, "w1_xor");

    // WIDTH=4 AND sweep, started together with a single request; inputs churn mid-sweep
    op4 = 3'd0;
    a4 = 4'h5;
    b4 = 4'h3;
    in_valid4 = 1'b1;
    sweep_start4 = 1'b1;
    tick();
    check("w4and.start_noval", 32'(out_valid4), 32'h0);
    check("w4and.start_busy", 32'(busy4), 32'h1);
    sweep_start4 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ea, eb;
      ea = 4'(i >> 4);
      eb = 4'(i);
      op4 = 3'(i);
      in_valid4 = i[0];
      sweep_start4 = (i % 7) == 3;
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      tick();
      check("w4and.valid", 32'(out_valid4), 32'h1);
      check("w4and.out_a", 32'(out_a4), 32'(ea));
      check("w4and.out_b", 32'(out_b4), 32'(eb));
      check("w4and.y", 32'(y4), 32'(ea & eb));
      check("w4and.done", 32'(done4), 32'(i == 255));
      check("w4and.busy", 32'(busy4), 32'(i != 255));
      if (i == 0 || i == 255)
        $display("w4and result %0d: a=%h b=%h y=%h done=%0d", i, out_a4, out_b4, y4, done4);
    end
    in_valid4 = 1'b0;
    sweep_start4 = 1'b0;
    tick();
    check("w4and.after_valid", 32'(out_valid4), 32'h0);
    check("w4and.after_busy", 32'(busy4), 32'h0);
    check("w4and.after_done", 32'(done4), 32'h0);

    // Reset mid-sweep (OR) at result 100
    op4 = 3'd1;
    sweep_start4 = 1'b1;
    tick();
    sweep_start4 = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      tick();
      if (i == 100) begin
        $display("w4or result 100: a=%h b=%h y=%h", out_a4, out_b4, y4);
        check("w4or.r100_a", 32'(out_a4), 32'h6);
        check("w4or.r100_b", 32'(out_b4), 32'h4);
        check("w4or.r100_y", 32'(y4), 32'h6);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("mid-sweep reset: valid=%0d busy=%0d done=%0d", out_valid4, busy4, done4);
    check_idle4("midrst");
    tick();
    check_idle4("midrst_hold");

    // New XOR sweep restarts at cnt=0; bounded wait for its done
    op4 = 3'd2;
    sweep_start4 = 1'b1;
    tick();
    sweep_start4 = 1'b0;
    tick();
    check("restart.a0", 32'(out_a4), 32'h0);
    check("restart.b0", 32'(out_b4), 32'h0);
    check("restart.y0", 32'(y4), 32'h0);
    tick();
    check("restart.b1", 32'(out_b4), 32'h1);
    check("restart.y1", 32'(y4), 32'h1);
    begin
      int n;
      n = 2;
      while (!done4 && n < 300) begin
        tick();
        n++;
      end
      $display("restart sweep: %0d results, done=%0d", n, done4);
      check("restart.len", 32'(n), 32'd256);
      check("restart.last_y", 32'(y4), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_op_unit.md
# logic_op_unit

Registered, parametrised two-operand bitwise logic unit with eight selectable functions (including implication and XOR) and a built-in truth-table sweep sequencer. In single mode it evaluates one operand pair per request. In sweep mode it walks every operand combination and emits one result per cycle. It replaces the team's fixed 1-bit implication/XOR gates with one configurable, self-exercising block for the logic-exercise datapath.

## Interface
- `WIDTH`, 4, operand/result width in bits (1..8).
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `op`  input  3  function select: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 IMP (~a|b), 7 CIMP (a|~b).
- `in_valid`  input  1  single-evaluation request.
- `a`  input  WIDTH  operand a.
- `b`  input  WIDTH  operand b.
- `sweep_start`  input  1  start a truth-table sweep using `op`.
- `y`  output  WIDTH  registered result, bitwise f(a,b).
- `out_a`  output  WIDTH  operand a that produced `y`.
- `out_b`  output  WIDTH  operand b that produced `y`.
- `out_valid`  output  1  `y`/`out_a`/`out_b` valid this cycle; one-cycle pulse per result.
- `busy`  output  1  sweep in progress.
- `done`  output  1  one-cycle pulse with the last sweep result.

## Operation
- States: IDLE, SWEEP. Sweep counter `cnt` is 2*WIDTH bits. A separate latched op register holds the sweep function.
- **Reset:** state IDLE, `cnt`=0, latched op=0. All outputs 0: `y`, `out_a`, `out_b`, `out_valid`, `busy`, `done`.
- **IDLE, `sweep_start`=1:**
  - latch `op`, `cnt`<=0, `busy`<=1, go to SWEEP.
  - `in_valid` in the same cycle is dropped; sweep has priority.
  - No `out_valid` is produced on this edge.
- **IDLE, `in_valid`=1, `sweep_start`=0:**
  - `y`<=f_op(`a`,`b`), `out_a`<=`a`, `out_b`<=`b`, `out_valid`<=1.
- **IDLE, neither request:** `out_valid`<=0. `y`/`out_a`/`out_b` hold their last values.
- **SWEEP, each cycle:**
  - operands are A=`cnt`[2W-1:W] and B=`cnt`[W-1:0], so B varies fastest;
  - `y`<=f_latched(A,B), `out_a`<=A, `out_b`<=B, `out_valid`<=1;
  - `cnt`<=`cnt`+1.
- **Sweep end:** when `cnt` = all-ones, also `done`<=1, `busy`<=0, `cnt`<=0, go to IDLE. The counter never wraps inside a sweep.
- **Ignored while in SWEEP:** `in_valid`, `sweep_start`, and changes on `op`, `a`, `b`.
- `rst` asserted mid-sweep: abort at that edge and apply the reset values. No `done` pulse.
- All function outputs are purely bitwise; there is no carry or cross-bit interaction.

## Timing
- **Single mode latency:** 1 cycle. A request sampled at edge t gives result with `out_valid`=1 after edge t, for exactly one cycle.
- **Single mode throughput:** back-to-back `in_valid` yields one result per cycle.
- **Sweep schedule:** `sweep_start` sampled at edge t:
  - `busy`=1 after edge t;
  - results after edges t+1 .. t+N, where N = 2^(2*WIDTH);
  - `done`=1 and `busy`=0 after edge t+N.
- **Re-arm:** a new request is accepted at edge t+N+1 at the earliest.
- **Sweep length:** N results. Examples: WIDTH=1 → 4 cycles; WIDTH=4 → 256 cycles.
- `out_valid` is high continuously during a sweep and low otherwise, unless single requests are being served.

## Test plan
- **Reset:** hold `rst` 2 cycles → all outputs 0 and `busy`=0. Release, no requests → outputs stay 0.
- **Single ops, WIDTH=4:** `a`=4'b1100, `b`=4'b1010, ops 0..7 back-to-back → `y` = 1000, 1110, 0110, 1001, 0111, 0001, 1011, 1101, each one cycle after its request, with `out_valid` high 8 consecutive cycles.
- **WIDTH=1 sweeps:**
  - op=6 (IMP) → `y` sequence 1,1,0,1 for (a,b)=00,01,10,11.
  - op=2 (XOR) → 0,1,1,0.
  - For both: `done` coincides with the 4th result, and `busy` is high 4 cycles.
- **WIDTH=4 sweep, op=0:** 256 results. Last result has `out_a`=`out_b`=4'hF, `y`=4'hF, `done`=1. Toggling `in_valid`/`op` mid-sweep has no effect.
- **Simultaneous `sweep_start`+`in_valid` in IDLE:** sweep starts, no single result is emitted, and the first `out_valid` has `out_a`=`out_b`=0.
- **Reset mid-sweep:** assert `rst` at result 100 of a WIDTH=4 sweep → next cycle all outputs 0, no `done`. A new sweep afterwards starts again from `cnt`=0.
